// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath types and constants.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : rv32i_pkg

// File: rtl/reg_read_port.sv
// Combinational register-file read mux; x0 always reads zero.
module reg_read_port
  import rv32i_pkg::*;
(
  input  word_t     regs_i [1:NREGS-1],
  input  reg_addr_t addr_i,
  output word_t     data_o
);

  // Select by explicit compare so index 0 never touches storage that does not exist.
  always_comb begin
    data_o = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (addr_i == reg_addr_t'(i)) data_o = regs_i[i];
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file_rv32i.sv
// RV32I integer register file: two async read ports, one clocked write port, x0 hardwired to zero.
module reg_file_rv32i
  import rv32i_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cu_rdwrite,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_in,
  output logic [XLEN-1:0]       rs1,
  output logic [XLEN-1:0]       rs2
);

  word_t regs_q [1:NREGS-1];
  logic  wr_en_d;

  assign wr_en_d = cu_rdwrite && (rd_addr != REG_ZERO);

  // NOTE: the array is cleared on reset because reads must never return X afterwards;
  // this costs a reset net on every flop, so it is not something to copy into plain RAMs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en_d) begin
      regs_q[rd_addr] <= rd_in;
    end
  end

  reg_read_port u_rs1_port (
    .regs_i (regs_q),
    .addr_i (rs1_addr),
    .data_o (rs1)
  );

  reg_read_port u_rs2_port (
    .regs_i (regs_q),
    .addr_i (rs2_addr),
    .data_o (rs2)
  );

endmodule : reg_file_rv32i

// File: tb/tb_reg_file_rv32i.sv
// Self-checking bench for reg_file_rv32i against an array model of the architectural registers.
module tb_reg_file_rv32i;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cu_rdwrite = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_in = '0;
  logic [31:0] rs1;
  logic [31:0] rs2;

  logic [31:0] model [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  reg_file_rv32i dut (
    .clock      (clock),
    .reset      (reset),
    .cu_rdwrite (cu_rdwrite),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .rd_in      (rd_in),
    .rs1        (rs1),
    .rs2        (rs2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one rising edge with the current inputs and update the model by the architectural rules.
  task automatic do_edge();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (cu_rdwrite && rd_addr != 5'd0) begin
      model[rd_addr] = rd_in;
    end
    #1;
  endtask

  task automatic read_both(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
    check({tag, "_rs1"}, rs1, (a1 == 5'd0) ? 32'h0 : model[a1]);
    check({tag, "_rs2"}, rs2, (a2 == 5'd0) ? 32'h0 : model[a2]);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    cu_rdwrite = 1'b1;
    rd_addr    = a;
    rd_in      = d;
    do_edge();
    cu_rdwrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset for two cycles, then sweep both ports.
    reset = 1'b1;
    do_edge();
    do_edge();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_both("reset_sweep", 5'(i), 5'(31 - i));
      check("reset_const", rs1, 32'h0);
    end

    // Basic write and dual-port read.
    write_reg(5'd1, 32'h1111_1111);
    rs1_addr = 5'd1;
    #1;
    check("wr_x1", rs1, 32'h1111_1111);
    write_reg(5'd2, 32'h2222_2222);
    rs1_addr = 5'd2;
    rs2_addr = 5'd1;
    #1;
    check("dual_rs1", rs1, 32'h2222_2222);
    check("dual_rs2", rs2, 32'h1111_1111);
    read_both("same_addr", 5'd2, 5'd2);

    // x0 guard.
    write_reg(5'd0, 32'hFFFF_FFFF);
    rs1_addr = 5'd0;
    #1;
    check("x0_guard", rs1, 32'h0);
    read_both("x0_keep", 5'd1, 5'd2);

    // Write enable low changes nothing.
    cu_rdwrite = 1'b0;
    rd_addr    = 5'd3;
    rd_in      = 32'hDEAD_BEEF;
    do_edge();
    rs1_addr = 5'd3;
    #1;
    check("we_low_x3", rs1, 32'h0);

    // Async read: address change with no clock edge.
    @(negedge clock);
    rs1_addr = 5'd1;
    #1;
    check("async_1", rs1, 32'h1111_1111);
    rs1_addr = 5'd2;
    #1;
    check("async_2", rs1, 32'h2222_2222);

    // No bypass: old value before the edge, new value after it.
    cu_rdwrite = 1'b1;
    rd_addr    = 5'd4;
    rd_in      = 32'h4444_4444;
    rs1_addr   = 5'd4;
    #1;
    check("nobypass_old", rs1, 32'h0);
    do_edge();
    cu_rdwrite = 1'b0;
    check("nobypass_new", rs1, 32'h4444_4444);

    // Reset has priority over a simultaneous write.
    reset      = 1'b1;
    cu_rdwrite = 1'b1;
    rd_addr    = 5'd5;
    rd_in      = 32'hA5A5_A5A5;
    do_edge();
    reset      = 1'b0;
    cu_rdwrite = 1'b0;
    read_both("rst_prio", 5'd5, 5'd1);
    check("rst_prio_x5", rs1, 32'h0);

    // Pattern sweep across every register.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      check("sweep_rs1", rs1, 32'(i) * 32'h0101_0101);
      check("sweep_rs2", rs2, 32'(i) * 32'h0101_0101);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      cu_rdwrite = $urandom_range(0, 3) != 0;
      rd_addr    = 5'($urandom_range(0, 31));
      rd_in      = $urandom;
      read_both("rand_pre", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      do_edge();
      read_both("rand_post", rd_addr, 5'($urandom_range(0, 31)));
    end
    reset      = 1'b0;
    cu_rdwrite = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_reg_file_rv32i
